lb_pixel_packer: RTL
====================

# lb_pixel_packer

Upstream feeder for the 100-byte line buffers: accepts a byte-wide pixel stream with a valid/ready handshake and packs four pixels into one 32-bit word. It issues single-cycle write pulses to one of NUM_LB line buffers and rotates to the next buffer after each full line. Buffer occupancy is tracked with a release input from the downstream window reader, so a line still in use is never overwritten.

## Interface
- NUM_LB, 4: number of line buffers driven (2..8)
- LINE_BYTES, 100: bytes per line; must be a multiple of 4 (words per line = LINE_BYTES/4 = 25)
- ROWS, 100: lines per frame

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_in  in  8  pixel byte
- pix_valid  in  1  pix_in valid
- pix_ready  out  1  block accepts pix_in this cycle
- lb_wr_en  out  NUM_LB  one-hot write strobe, bit i = buffer i
- lb_wr_data  out  32  packed word; first accepted pixel in [7:0], fourth in [31:24]
- lb_release  in  1  one-cycle pulse: oldest completed line consumed
- lines_avail  out  4  completed, unreleased lines
- wr_sel  out  3  buffer index currently being filled
- line_done  out  1  one-cycle pulse on line completion
- frame_done  out  1  one-cycle pulse on completion of line ROWS-1
- err  out  1  sticky: release with lines_avail==0

## Operation
- Reset values: pix_ready 0 during rst, lb_wr_en 0, lb_wr_data 0, lines_avail 0, wr_sel 0, line_done 0, frame_done 0, err 0; byte count, word count and row count 0; FSM in FILL.
- FSM states:
  - FILL: pix_ready = 1 unless a line start is blocked. On accept, the byte shifts into the pack register at lane byte_cnt and byte_cnt increments. Accepting the 4th byte moves the FSM to WRITE.
  - WRITE: lb_wr_en[wr_sel] = 1 for exactly this cycle, pix_ready = 0. Next state is GAP.
  - GAP: no strobe, pix_ready = 0. Next state is FILL. This gap guarantees the line buffer sees wr_en deasserted between words.
- Line start blocking: when byte_cnt==0 and word_cnt==0, pix_ready = 0 while lines_avail + 1 > NUM_LB. The buffer at wr_sel must not hold an unreleased line.
- Line end: on the WRITE of word LINE_BYTES/4-1:
  - word_cnt clears to 0.
  - wr_sel advances, wrapping NUM_LB-1 to 0.
  - lines_avail increments.
  - line_done pulses in the GAP cycle.
  - row_cnt increments. At ROWS-1, row_cnt wraps to 0 and frame_done pulses together with line_done. wr_sel is not reset at frame boundaries.
- Release: lb_release decrements lines_avail.
  - Release in the same cycle as a line-end increment: net no change.
  - Release with lines_avail==0 (and no simultaneous increment): ignored, err is set and stays set until rst.
- pix_valid without pix_ready: no state change, and the byte is not consumed.
- lb_wr_data holds the last written word until the next WRITE.
- Reset mid-line: the partial word and line are discarded. Downstream buffer write pointers must be reset by the same rst at top level, otherwise their alignment is lost.

## Timing
- Pixel throughput: at most 4 pixels per 6 cycles (4 FILL accepts + WRITE + GAP).
- If the 4th byte is accepted at edge N:
  - lb_wr_en is high in cycle N..N+1 (one cycle), with lb_wr_data valid in the same cycle.
  - The GAP cycle follows.
  - pix_ready returns high in the cycle after GAP.
- lines_avail, wr_sel and line_done update at the edge ending WRITE, so they are visible in the GAP cycle.
- lb_release is sampled every cycle, in every state.

## Test plan
- Reset then bytes 0x01,0x02,0x03,0x04 back-to-back:
  - lb_wr_en = 4'b0001 for one cycle with lb_wr_data = 0x04030201.
  - pix_ready is low for exactly 2 cycles, then high.
- Stream 100 bytes with continuous pix_valid:
  - 25 strobes, all on lb_wr_en[0].
  - line_done pulses once, lines_avail = 1, wr_sel = 1.
  - Total 150 cycles from first accept to pix_ready re-high.
- Stream 5 lines with NUM_LB = 4 and no release:
  - After 4 lines, lines_avail = 4 and pix_ready stays 0 indefinitely.
  - One lb_release brings lines_avail to 3, pix_ready rises the next cycle, and line 5 strobes lb_wr_en[0].
- lb_release coincident with the line-end WRITE while lines_avail = 2: lines_avail stays 2 and err stays 0.
- lb_release with lines_avail = 0: err = 1 and remains 1 after further normal traffic until rst.
- Stream ROWS = 100 lines with release after every line_done:
  - frame_done pulses once, coincident with the 100th line_done.
  - wr_sel = 100 mod 4 = 0.
- Reset mid-word after 2 bytes, then send 4 new bytes: the single strobe carries only the new bytes.

Source files
------------

// File: rtl/lb_pixel_packer.sv
// -----------------------------------------------------------------------------
// lb_pixel_packer
//
// Feeds the line buffers. A byte-wide pixel stream arrives on a valid/ready
// handshake. Every four accepted pixels are packed into one 32-bit word, with
// the first pixel in bits [7:0]. The word is written to the line buffer
// selected by wr_sel using a single-cycle strobe. After a full line of
// LINE_BYTES/4 words, the block moves on to the next buffer. Completed lines
// are counted in lines_avail until the downstream window reader releases them.
// A new line is held off while every buffer still holds an unreleased line.
//
// Each word takes three phases:
//   FILL  : accept up to four bytes
//   WRITE : one-cycle strobe to the selected buffer
//   GAP   : dead cycle, so the buffer sees wr_en low between words
// Throughput is therefore at most 4 pixels per 6 cycles.
//
// Parameters
//   NUM_LB      number of line buffers driven (2..8)
//   LINE_BYTES  bytes per line, must be a multiple of 4
//   ROWS        lines per frame
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   pix_in       pixel byte
//   pix_valid    pix_in valid
//   pix_ready    pix_in is accepted this cycle when pix_valid is also high
//   lb_wr_en     one-hot write strobe; bit i addresses buffer i
//   lb_wr_data   packed word; first pixel in [7:0], fourth in [31:24]
//   lb_release   one-cycle pulse: the oldest completed line has been consumed
//   lines_avail  number of completed, unreleased lines
//   wr_sel       index of the buffer currently being filled
//   line_done    one-cycle pulse in the GAP cycle after the last word of a line
//   frame_done   one-cycle pulse together with line_done for line ROWS-1
//   err          sticky: a release arrived with nothing to release
//
// Downstream buffer write pointers must be reset by the same rst. A reset in
// mid-line discards the partial word and the partial line here, so the
// buffers must discard them too or alignment is lost.
// -----------------------------------------------------------------------------
module lb_pixel_packer #(
  parameter int NUM_LB     = 4,
  parameter int LINE_BYTES = 100,
  parameter int ROWS       = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        pix_in,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [NUM_LB-1:0] lb_wr_en,
  output logic [31:0]       lb_wr_data,
  input  logic              lb_release,
  output logic [3:0]        lines_avail,
  output logic [2:0]        wr_sel,
  output logic              line_done,
  output logic              frame_done,
  output logic              err
);

  localparam int WORDS  = LINE_BYTES / 4;
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
  localparam logic [2:0]        LAST_SEL  = 3'(NUM_LB - 1);
  localparam logic [3:0]        LB_COUNT  = 4'(NUM_LB);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [1:0]        byte_cnt;
  logic [WORD_W-1:0] word_cnt;
  logic [ROW_W-1:0]  row_cnt;

  // Lanes 0..2 of the word being assembled. Lane 3 comes straight from
  // pix_in when the fourth byte is accepted.
  logic [23:0]       pack_p0;

  logic              line_start;
  logic              start_blocked;
  logic              accept;
  logic              last_byte;
  logic              line_end;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Decode a buffer index into a one-hot strobe vector.
  function automatic logic [NUM_LB-1:0] sel_onehot(input logic [2:0] sel);
    logic [NUM_LB-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_LB; i++) begin
      if (sel == 3'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // Next buffer index, wrapping from NUM_LB-1 back to 0.
  function automatic logic [2:0] sel_next(input logic [2:0] sel);
    return (sel == LAST_SEL) ? 3'd0 : sel + 3'd1;
  endfunction

  // Place one byte into lane 0..2 of the partial word.
  function automatic logic [23:0] lane_insert(input logic [23:0] pack,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  pix);
    logic [23:0] r;
    r = pack;
    case (lane)
      2'd0:    r[7:0]   = pix;
      2'd1:    r[15:8]  = pix;
      2'd2:    r[23:16] = pix;
      default: r        = pack;
    endcase
    return r;
  endfunction

  // Occupancy update. A release in the same cycle as a line-end increment
  // cancels it. A lone release at zero is ignored here; err flags it.
  function automatic logic [3:0] avail_next(input logic [3:0] avail,
                                            input logic       inc,
                                            input logic       dec);
    logic [3:0] r;
    r = avail;
    if (inc && !dec) begin
      r = avail + 4'd1;
    end else if (dec && !inc && avail != 4'd0) begin
      r = avail - 4'd1;
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    line_start    = (byte_cnt == 2'd0) && (word_cnt == '0);
    // Equivalent to lines_avail + 1 > NUM_LB. At a line start, wr_sel points
    // at the buffer that would be overwritten, and that buffer is still
    // unreleased exactly when every buffer is occupied.
    start_blocked = line_start && (lines_avail >= LB_COUNT);
    pix_ready     = !rst && (state == S_FILL) && !start_blocked;
    accept        = pix_ready && pix_valid;
    last_byte     = (byte_cnt == 2'd3);
    line_end      = (state == S_WRITE) && (word_cnt == LAST_WORD);
  end

  // ---------------------------------------------------------------------------
  // Stage p0: partial-word assembly (data only, no reset needed)
  // ---------------------------------------------------------------------------
  // Stale lanes left after a reset are harmless. byte_cnt restarts at 0, so
  // every lane is rewritten before the next word is emitted.
  always_ff @(posedge clk) begin
    if (accept && !last_byte) begin
      pack_p0 <= lane_insert(pack_p0, byte_cnt, pix_in);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: FSM, write strobe, line/frame counters and occupancy
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FILL;
      byte_cnt    <= 2'd0;
      word_cnt    <= '0;
      row_cnt     <= '0;
      wr_sel      <= 3'd0;
      lines_avail <= 4'd0;
      lb_wr_en    <= '0;
      lb_wr_data  <= 32'd0;
      line_done   <= 1'b0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
    end else begin
      lb_wr_en   <= '0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;

      case (state)
        S_FILL: begin
          if (accept) begin
            // byte_cnt wraps back to 0 on the fourth byte.
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              lb_wr_en   <= sel_onehot(wr_sel);
              lb_wr_data <= {pix_in, pack_p0};
              state      <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          state <= S_GAP;
          if (line_end) begin
            word_cnt  <= '0;
            wr_sel    <= sel_next(wr_sel);
            line_done <= 1'b1;
            // wr_sel keeps rotating across frames; only row_cnt wraps here.
            if (row_cnt == LAST_ROW) begin
              row_cnt    <= '0;
              frame_done <= 1'b1;
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end else begin
            word_cnt <= word_cnt + WORD_W'(1);
          end
        end

        S_GAP: begin
          state <= S_FILL;
        end

        default: begin
          state <= S_FILL;
        end
      endcase

      // Release is honoured in every state, independent of the FSM.
      lines_avail <= avail_next(lines_avail, line_end, lb_release);
      if (lb_release && !line_end && lines_avail == 4'd0) begin
        err <= 1'b1;
      end
    end
  end

endmodule
